// File: rtl/pushbutton_input_port.sv
// pushbutton_input_port: synchronises and debounces four pushbuttons, keeps sticky
// press flags, and returns levels or flags to the CPU data bus on an IN read.
`default_nettype none

module pushbutton_input_port #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] PUSHBUTTONS,
  input  logic       rd_en,
  input  logic       rd_sel,
  output logic [3:0] DATA_OUT,
  output logic       DATA_OE,
  output logic [3:0] LEVEL,
  output logic [3:0] PRESSED,
  output logic       IRQ
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]            sync1_q;
  logic [3:0]            sync2_q;
  logic [3:0]            level_q;
  logic [3:0]            level_d;
  logic [3:0]            pressed_q;
  logic [3:0]            pressed_d;
  logic [3:0]            set_w;
  logic                  clr_w;
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;

  // A button's counter only advances while sync2 disagrees with its stable level;
  // any agreement discards the progress, so short glitches never qualify.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    set_w   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        set_w[i]   = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Clear-on-read keeps any bit being set on the same edge so a press is never lost.
  assign clr_w     = rd_en & rd_sel;
  assign pressed_d = clr_w ? set_w : (pressed_q | set_w);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 4'b0000;
      sync2_q   <= 4'b0000;
      level_q   <= 4'b0000;
      pressed_q <= 4'b0000;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= PUSHBUTTONS;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign DATA_OE  = rd_en & ~reset;
  assign DATA_OUT = DATA_OE ? (rd_sel ? pressed_q : level_q) : 4'b0000;
  assign LEVEL    = level_q;
  assign PRESSED  = pressed_q;
  assign IRQ      = |pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_pushbutton_input_port.sv
// tb_pushbutton_input_port: directed stimulus with a queue-based scoreboard for
// the pushbutton input port (DB_CYCLES=4).
`default_nettype none

module tb_pushbutton_input_port;

  logic       clk;
  logic       reset;
  logic [3:0] PUSHBUTTONS;
  logic       rd_en;
  logic       rd_sel;
  logic [3:0] DATA_OUT;
  logic       DATA_OE;
  logic [3:0] LEVEL;
  logic [3:0] PRESSED;
  logic       IRQ;

  logic       probe;
  int         total;
  int         bad;

  typedef struct {
    string      tag;
    logic       oe;
    logic [3:0] dout;
    logic [3:0] level;
    logic [3:0] pressed;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];

  pushbutton_input_port #(
    .DB_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PUSHBUTTONS(PUSHBUTTONS),
    .rd_en(rd_en),
    .rd_sel(rd_sel),
    .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE),
    .LEVEL(LEVEL),
    .PRESSED(PRESSED),
    .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation whenever the DUT drives the bus or the bench probes.
  always @(negedge clk) begin
    if (probe || DATA_OE) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_output: oe=%b dout=%b with no expectation queued", DATA_OE, DATA_OUT);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (DATA_OE !== e.oe || DATA_OUT !== e.dout || LEVEL !== e.level ||
            PRESSED !== e.pressed || IRQ !== e.irq) begin
          bad = bad + 1;
          $display("FAIL %s: got oe=%b dout=%b level=%b pressed=%b irq=%b, want oe=%b dout=%b level=%b pressed=%b irq=%b",
                   e.tag, DATA_OE, DATA_OUT, LEVEL, PRESSED, IRQ,
                   e.oe, e.dout, e.level, e.pressed, e.irq);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the expected view of the current cycle, present it for one edge, then idle.
  task automatic observe(input string tag, input logic en, input logic sel,
                         input logic oe, input logic [3:0] dout, input logic [3:0] lvl,
                         input logic [3:0] prs, input logic irq);
    exp_t e;
    e.tag = tag; e.oe = oe; e.dout = dout; e.level = lvl; e.pressed = prs; e.irq = irq;
    exp_q.push_back(e);
    rd_en  = en;
    rd_sel = sel;
    probe  = 1'b1;
    tick(1);
    rd_en  = 1'b0;
    rd_sel = 1'b0;
    probe  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    probe = 1'b0;
    reset = 1'b1;
    PUSHBUTTONS = 4'b0000;
    rd_en  = 1'b0;
    rd_sel = 1'b0;
    #10 reset = 1'b0;
    tick(1);

    // Post-reset idle state
    observe("reset_read_lvl", 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    observe("reset_idle",     0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);

    // Clean press of bit0: qualifies on the 6th edge after the first sampling edge
    PUSHBUTTONS = 4'b0001;
    tick(4);
    observe("b0_edge4",      0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    observe("b0_edge5",      0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    observe("b0_level_read", 1, 0, 1, 4'b0001, 4'b0001, 4'b0001, 1);
    observe("b0_after_read", 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 1);

    // Three-cycle glitch on bit1 never qualifies
    PUSHBUTTONS = 4'b0011;
    tick(3);
    PUSHBUTTONS = 4'b0001;
    tick(4);
    observe("glitch_b1",      0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 1);
    observe("clear_b0",       1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 1);
    observe("after_clear_b0", 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);

    // Press and release bit2, then read flags twice
    PUSHBUTTONS = 4'b0101;
    tick(8);
    PUSHBUTTONS = 4'b0001;
    tick(8);
    observe("b2_released",   0, 0, 0, 4'b0000, 4'b0001, 4'b0100, 1);
    observe("b2_flag_read",  1, 1, 1, 4'b0100, 4'b0001, 4'b0100, 1);
    observe("b2_cleared",    0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);
    observe("b2_second_read",1, 1, 1, 4'b0000, 4'b0001, 4'b0000, 0);

    // Re-press bit0, then time bit3's qualification onto the clear edge
    PUSHBUTTONS = 4'b0000;
    tick(8);
    PUSHBUTTONS = 4'b0001;
    tick(8);
    PUSHBUTTONS = 4'b1001;
    tick(5);
    observe("simul_read",     1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 1);
    observe("simul_after",    0, 0, 0, 4'b0000, 4'b1001, 4'b1000, 1);
    observe("simul_lvl_read", 1, 0, 1, 4'b1001, 4'b1001, 4'b1000, 1);
    observe("lvl_read_keeps", 0, 0, 0, 4'b0000, 4'b1001, 4'b1000, 1);

    // Reset mid-debounce with the buttons held throughout
    PUSHBUTTONS = 4'b0111;
    tick(3);
    reset = 1'b1;
    observe("in_reset",      1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    reset = 1'b0;
    tick(5);
    observe("requal_edge6",  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    observe("requal_done",   0, 0, 0, 4'b0000, 4'b0111, 4'b0111, 1);

    tick(2);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
